btn_cmd: RTL and testbench

Button front end for the puzzle machine: the input-side counterpart of the display path in `io`. Samples the five raw push-buttons, synchronizes and debounces them, and turns each fresh press into a single encoded move command. Each command is held on a valid/ack handshake until the core consumes it. Sits between the board pins and the decoder/register side of the design, on the divided `clk` domain.

---
 rtl/puzzle_pkg.sv | 37 +++
 rtl/btn_debounce.sv | 51 +++++
 rtl/btn_cmd.sv | 96 +++++++++
 tb/tb_btn_cmd.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/puzzle_pkg.sv
// Shared definitions for the puzzle machine: move command codes, the button
// FSM state type and small encoding helpers used by the button front end.
package puzzle_pkg;

   localparam logic [2:0] CMD_NONE    = 3'd0;
   localparam logic [2:0] CMD_UP      = 3'd1;
   localparam logic [2:0] CMD_DOWN    = 3'd2;
   localparam logic [2:0] CMD_LEFT    = 3'd3;
   localparam logic [2:0] CMD_RIGHT   = 3'd4;
   localparam logic [2:0] CMD_RESTART = 3'd5;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PEND     = 2'd1,
      WAIT_REL = 2'd2
   } state_t;

   // Lowest-index pressed button wins.
   function automatic logic [2:0] first_press_code(input logic [4:0] rise);
      logic [2:0] code;
      casez (rise)
         5'b????1: code = CMD_UP;
         5'b???10: code = CMD_DOWN;
         5'b??100: code = CMD_LEFT;
         5'b?1000: code = CMD_RIGHT;
         5'b10000: code = CMD_RESTART;
         default:  code = CMD_NONE;
      endcase
      return code;
   endfunction

   // Presses that lose arbitration: everything except the lowest set bit.
   function automatic logic [4:0] extra_presses(input logic [4:0] rise);
      return rise & (rise - 5'd1);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button bit: two-flop synchronizer, consecutive-cycle debounce counter
// and a registered rising-edge pulse of the debounced level.
module btn_debounce #(
   parameter int DB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic stable,
   output logic rise
);

   localparam int             CW      = $clog2(DB_CYCLES);
   localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

   logic          meta_r;
   logic          sync_r;
   logic          stable_r;
   logic          stable_q_r;
   logic          rise_r;
   logic [CW-1:0] cnt_r;

   // Synchronize, debounce and register the press edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_r     <= 1'b0;
         sync_r     <= 1'b0;
         stable_r   <= 1'b0;
         stable_q_r <= 1'b0;
         rise_r     <= 1'b0;
         cnt_r      <= {CW{1'b0}};
      end else begin
         meta_r     <= btn;
         sync_r     <= meta_r;
         stable_q_r <= stable_r;
         rise_r     <= stable_r & ~stable_q_r;
         if (sync_r == stable_r) begin
            cnt_r <= {CW{1'b0}};
         end else if (cnt_r == CNT_MAX) begin
            stable_r <= ~stable_r;
            cnt_r    <= {CW{1'b0}};
         end else begin
            cnt_r <= cnt_r + CW'(1);
         end
      end
   end

   assign stable = stable_r;
   assign rise   = rise_r;

endmodule

// File: rtl/btn_cmd.sv
// Button front end: debounces the five buttons and turns each fresh press
// into one move command held on a valid/ack handshake.
module btn_cmd
   import puzzle_pkg::*;
#(
   parameter int DB_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] btn,
   input  logic       cmd_ack,
   output logic       cmd_valid,
   output logic [2:0] cmd,
   output logic       drop
);

   logic [4:0] stable_s;
   logic [4:0] rise_s;

   for (genvar g = 0; g < 5; g++) begin : g_db
      btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
         .clk    (clk),
         .rst_n  (rst_n),
         .btn    (btn[g]),
         .stable (stable_s[g]),
         .rise   (rise_s[g])
      );
   end

   state_t     state_r;
   state_t     state_next_s;
   logic [2:0] cmd_r;
   logic [2:0] cmd_next_s;
   logic       valid_r;
   logic       valid_next_s;
   logic       drop_r;
   logic       drop_next_s;

   // Next state and next output values; outputs are registered below.
   always_comb begin
      state_next_s = state_r;
      cmd_next_s   = CMD_NONE;
      drop_next_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (|rise_s) begin
               state_next_s = PEND;
               cmd_next_s   = first_press_code(rise_s);
               drop_next_s  = |extra_presses(rise_s);
            end else begin
               state_next_s = IDLE;
            end
         end
         PEND: begin
            drop_next_s = |rise_s;
            if (cmd_ack) begin
               state_next_s = WAIT_REL;
            end else begin
               cmd_next_s = cmd_r;
            end
         end
         WAIT_REL: begin
            drop_next_s = |rise_s;
            if (stable_s == 5'd0) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = WAIT_REL;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
      valid_next_s = (state_next_s == PEND);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
         cmd_r   <= CMD_NONE;
         valid_r <= 1'b0;
         drop_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         cmd_r   <= cmd_next_s;
         valid_r <= valid_next_s;
         drop_r  <= drop_next_s;
      end
   end

   assign cmd_valid = valid_r;
   assign cmd       = cmd_r;
   assign drop      = drop_r;

endmodule

// File: tb/tb_btn_cmd.sv
// Bench for btn_cmd: directed scenarios with literal latency expectations plus
// randomized buttons/ack/reset checked every cycle against a behavioural model.
module tb_btn_cmd;

   localparam int DB    = 4;
   localparam int WMASK = (1 << DB) - 1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] btn;
   logic       cmd_ack;
   logic       cmd_valid;
   logic [2:0] cmd;
   logic       drop;

   always #5 clk = ~clk;

   btn_cmd #(.DB_CYCLES(DB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn       (btn),
      .cmd_ack   (cmd_ack),
      .cmd_valid (cmd_valid),
      .cmd       (cmd),
      .drop      (drop)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Debounce: a level flips once the last DB synchronized samples all differ
   // from it. Commands: one per fresh press, lowest button wins, extras dropped.
   logic [4:0] m_s1 = '0, m_s2 = '0, m_stable = '0, m_stable_q = '0, m_rise = '0;
   int         m_win [5];
   bit         m_pend = 0, m_wait = 0, model_live = 0;
   int         m_cmd = 0;
   int         exp_valid = 0, exp_cmd = 0, exp_drop = 0;

   initial begin
      logic [4:0] seen_sync, old_stable, old_rise;
      int         drop_now, low;
      for (int i = 0; i < 5; i++) m_win[i] = 0;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_stable_q = '0; m_rise = '0;
            for (int i = 0; i < 5; i++) m_win[i] = 0;
            m_pend = 0; m_wait = 0; m_cmd = 0;
            exp_valid = 0; exp_cmd = 0; exp_drop = 0;
         end else begin
            seen_sync  = m_s2;
            old_stable = m_stable;
            old_rise   = m_rise;
            m_s2 = m_s1;
            m_s1 = btn;
            for (int i = 0; i < 5; i++) begin
               m_win[i] = ((m_win[i] << 1) | int'(seen_sync[i])) & WMASK;
               if (m_win[i] == (old_stable[i] ? 0 : WMASK)) m_stable[i] = ~old_stable[i];
            end
            m_rise     = old_stable & ~m_stable_q;
            m_stable_q = old_stable;
            drop_now = 0;
            if (m_pend) begin
               if (old_rise != 0) drop_now = 1;
               if (cmd_ack) begin m_pend = 0; m_wait = 1; end
            end else if (m_wait) begin
               if (old_rise != 0) drop_now = 1;
               if (old_stable == 0) m_wait = 0;
            end else if (old_rise != 0) begin
               low = 0;
               for (int i = 4; i >= 0; i--) if (old_rise[i]) low = i;
               m_cmd  = low + 1;
               m_pend = 1;
               if ($countones(old_rise) > 1) drop_now = 1;
            end
            exp_valid = m_pend ? 1 : 0;
            exp_cmd   = m_pend ? m_cmd : 0;
            exp_drop  = drop_now;
         end
         model_live = 1;
      end
   end

   // Every-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (model_live) begin
            check("model_valid", int'(cmd_valid), exp_valid);
            check("model_cmd",   int'(cmd),       exp_cmd);
            check("model_drop",  int'(drop),      exp_drop);
         end
      end
   end

   // Event counters sampled mid-cycle, read by the directed scenarios.
   int drop_seen = 0, valid_rise = 0;
   bit prev_valid = 0;
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (drop === 1'b1) drop_seen++;
         if (cmd_valid === 1'b1 && !prev_valid) valid_rise++;
         prev_valid = (cmd_valid === 1'b1);
      end
   end

   // ---------------- directed helpers ----------------
   // Caller has just changed an input at a negedge; the next edge is k.
   task automatic expect_cmd_after(input string name, input int code);
      repeat (7) @(negedge clk);
      check({name, "_early"}, int'(cmd_valid), 0);
      @(negedge clk);
      check({name, "_valid"}, int'(cmd_valid), 1);
      check({name, "_cmd"},   int'(cmd),       code);
   endtask

   task automatic press_check(input string name, input logic [4:0] val, input int code);
      btn = val;
      expect_cmd_after(name, code);
   endtask

   task automatic settle();
      btn     = 5'd0;
      cmd_ack = 1'b1;
      repeat (20) @(negedge clk);
      cmd_ack = 1'b0;
      @(negedge clk);
   endtask

   int d0, v0, cnt;

   initial begin
      rst_n   = 1'b0;
      btn     = 5'd0;
      cmd_ack = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", int'(cmd_valid), 0);
      check("rst_cmd",   int'(cmd),       0);
      check("rst_drop",  int'(drop),      0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Clean press, no ack: command holds for 20 cycles.
      press_check("t1", 5'b00001, 1);
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (cmd_valid === 1'b1 && cmd === 3'd1) cnt++;
      end
      check("t1_hold", cnt, 20);
      settle();

      // Bounce then hold.
      d0 = drop_seen; v0 = valid_rise;
      btn = 5'b00100; @(negedge clk);
      btn = 5'b00000; @(negedge clk);
      btn = 5'b00100; @(negedge clk);
      btn = 5'b00000; @(negedge clk);
      press_check("t2", 5'b00100, 3);
      repeat (5) @(negedge clk);
      check("t2_drops", drop_seen - d0, 0);
      check("t2_cmds",  valid_rise - v0, 1);
      settle();

      // Simultaneous press of down and right.
      d0 = drop_seen;
      press_check("t3", 5'b01010, 2);
      check("t3_drop_now", int'(drop), 1);
      @(negedge clk);
      check("t3_drop_gone", int'(drop), 0);
      cmd_ack = 1'b1; @(negedge clk); cmd_ack = 1'b0;
      check("t3_acked", int'(cmd_valid), 0);
      btn = 5'd0; v0 = valid_rise;
      repeat (25) @(negedge clk);
      check("t3_no_second", valid_rise - v0, 0);
      check("t3_drop_total", drop_seen - d0, 1);
      settle();

      // Ack on the first valid cycle; held restart does not repeat.
      cmd_ack = 1'b1;
      press_check("t4", 5'b10000, 5);
      @(negedge clk);
      check("t4_one_cycle", int'(cmd_valid), 0);
      cmd_ack = 1'b0; v0 = valid_rise;
      repeat (20) @(negedge clk);
      check("t4_no_repeat", valid_rise - v0, 0);
      btn = 5'd0;
      repeat (15) @(negedge clk);
      press_check("t4_right", 5'b01000, 4);
      settle();

      // Press while pending: dropped, command unchanged.
      press_check("t5", 5'b00001, 1);
      d0 = drop_seen;
      btn = 5'b00011;
      repeat (12) @(negedge clk);
      check("t5_drop", drop_seen - d0, 1);
      check("t5_valid", int'(cmd_valid), 1);
      check("t5_cmd", int'(cmd), 1);
      cmd_ack = 1'b1; @(negedge clk); cmd_ack = 1'b0;
      check("t5_acked", int'(cmd_valid), 0);
      settle();

      // Reset while pending with up held: command reissued.
      press_check("t6", 5'b00001, 1);
      rst_n = 1'b0;
      @(negedge clk);
      check("t6_rst_valid", int'(cmd_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      expect_cmd_after("t6_reissue", 1);
      settle();

      // Randomized buttons, glitches, ack and occasional reset.
      for (int c = 0; c < 4000; c++) begin
         for (int b = 0; b < 5; b++) begin
            if ($urandom_range(0, 39) == 0) btn[b] = ~btn[b];
         end
         if ($urandom_range(0, 29) == 0) btn[$urandom_range(0, 4)] ^= 1'b1;
         cmd_ack = ($urandom_range(0, 3) == 0);
         rst_n   = ($urandom_range(0, 599) != 0);
         @(negedge clk);
      end
      rst_n = 1'b1;
      settle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
